// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock, rounds 0..ROUNDS, on a valid/ready stream.
// Build option AES_KEY_STALL_EN: when defined, rk_ready back-pressures each beat; otherwise every EXPAND cycle is a beat.
module aes_key_expand #(
    parameter int SIZE   = 128,
    parameter int ROUNDS = 10
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [SIZE-1:0] key,
    input  logic            key_valid,
    output logic            key_ready,
    output logic [SIZE-1:0] round_key,
    output logic [3:0]      rk_index,
    output logic            rk_valid,
    input  logic            rk_ready,
    output logic            done
);

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_e;

    // FIPS-197 S-box, entry [a] is SubBytes(a).
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_e          state_q, state_d;
    logic [SIZE-1:0] wkey_q, wkey_d;
    logic [3:0]      idx_q, idx_d;
    logic            done_q, done_d;

    logic            beat;
    logic [7:0]      rcon;
    logic [31:0]     w0, w1, w2, w3;
    logic [31:0]     rot_w3, sub_w3, t_word;
    logic [31:0]     n0, n1, n2, n3;

    // Round constant for the key being produced, i.e. rcon[idx_q + 1].
    always_comb begin
        rcon = 8'h00;
        case (idx_q)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign w0 = wkey_q[127:96];
    assign w1 = wkey_q[95:64];
    assign w2 = wkey_q[63:32];
    assign w3 = wkey_q[31:0];

    assign rot_w3 = {w3[23:0], w3[31:24]};
    assign sub_w3 = {SBOX[rot_w3[31:24]], SBOX[rot_w3[23:16]],
                     SBOX[rot_w3[15:8]],  SBOX[rot_w3[7:0]]};
    assign t_word = sub_w3 ^ {rcon, 24'h000000};

    assign n0 = w0 ^ t_word;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign key_ready = (state_q == IDLE);
    assign rk_valid  = (state_q == EXPAND);
    assign round_key = wkey_q;
    assign rk_index  = idx_q;
    assign done      = done_q;

`ifdef AES_KEY_STALL_EN
    assign beat = rk_valid & rk_ready;
`else
    // rk_ready has no effect here; the OR keeps the port referenced without changing the beat.
    assign beat = rk_valid & (rk_ready | 1'b1);
`endif

    always_comb begin
        state_d = state_q;
        wkey_d  = wkey_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    wkey_d  = key;
                    idx_d   = 4'd0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                if (beat) begin
                    if (idx_q == 4'(ROUNDS)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        wkey_d = {n0, n1, n2, n3};
                        idx_d  = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wkey_q  <= '0;
            idx_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wkey_q  <= wkey_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed + random bench for aes_key_expand; expected round keys come from a FIPS-197 style word model
// whose S-box is derived from GF(2^8) inversion and the affine map.
module tb_aes_key_expand;

  // ---------------- clock / reset ----------------
  logic         clock = 1'b0;
  logic         reset_n;
  logic [127:0] key;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   rk_index;
  logic         rk_valid;
  logic         rk_ready;
  logic         done;

  always #5 clock = ~clock;

  aes_key_expand #(.SIZE(128), .ROUNDS(10)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .key       (key),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .round_key (round_key),
    .rk_index  (rk_index),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .done      (done)
  );

  // ---------------- scoreboard state ----------------
  int           n_checks = 0;
  int           n_fails  = 0;
  logic [7:0]   sbox_m [256];
  logic [127:0] exp_q [$];
  logic [127:0] cap_rk1;
  logic [127:0] cap_rk10;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
  endfunction

  // Standard w[0..43] word recurrence; pushes the 11 round keys in order.
  task automatic model_push(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) exp_q.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic accept_key(input logic [127:0] k);
    check("key_ready_idle", key_ready, 1);
    key       = k;
    key_valid = 1'b1;
    model_push(k);
    @(negedge clock);
    key_valid = 1'b0;
    key       = rand128();
  endtask

  // Called at the negedge of the rk0 cycle; returns at the negedge of the done cycle (or after an abort).
  task automatic expand_check(input int stall_at, input int stall_len, input int inj_beat,
                              input logic [127:0] inj_key, input int abort_at);
    logic [127:0] e;
    for (int i = 0; i <= 10; i++) begin
      if (exp_q.size() == 0) begin
        check("exp_q_empty", 1, 0);
        return;
      end
      e = exp_q.pop_front();
      check("rk_valid", rk_valid, 1);
      check("rk_index", rk_index, i);
      check("round_key", round_key, e);
      check("key_ready_busy", key_ready, 0);
      check("done_busy", done, 0);
      if (i == 1)  cap_rk1  = round_key;
      if (i == 10) cap_rk10 = round_key;
      if (i == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("abort_rk_valid", rk_valid, 0);
        check("abort_round_key", round_key, 0);
        check("abort_rk_index", rk_index, 0);
        check("abort_done", done, 0);
        check("abort_key_ready", key_ready, 1);
        exp_q.delete();
        return;
      end
      if (inj_beat >= 0) begin
        if (i == inj_beat) begin
          key       = inj_key;
          key_valid = 1'b1;
        end else if (i == inj_beat + 1) begin
          key_valid = 1'b0;
        end
      end
`ifdef AES_KEY_STALL_EN
      if (i == stall_at) begin
        rk_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clock);
          check("stall_rk_valid", rk_valid, 1);
          check("stall_rk_index", rk_index, i);
          check("stall_round_key", round_key, e);
        end
        rk_ready = 1'b1;
      end
`else
      rk_ready = (stall_at >= 0 && i >= stall_at && i < stall_at + stall_len) ? 1'b0 : 1'b1;
`endif
      @(negedge clock);
    end
    rk_ready = 1'b1;
    check("done_pulse", done, 1);
    check("key_ready_done", key_ready, 1);
    check("rk_valid_done", rk_valid, 0);
  endtask

  task automatic idle_check();
    @(negedge clock);
    check("done_cleared", done, 0);
    check("rk_valid_idle", rk_valid, 0);
    check("key_ready_back", key_ready, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] k;
    reset_n   = 1'b0;
    key       = '0;
    key_valid = 1'b0;
    rk_ready  = 1'b1;
    build_sbox();
    #1;
    check("rst_key_ready", key_ready, 1);
    check("rst_rk_valid", rk_valid, 0);
    check("rst_round_key", round_key, 0);
    check("rst_rk_index", rk_index, 0);
    check("rst_done", done, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // FIPS-197 key
    accept_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    expand_check(-1, 0, -1, '0, -1);
    check("fips_rk1", cap_rk1, 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_rk10", cap_rk10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    idle_check();

    // zero key
    accept_key(128'h0);
    expand_check(-1, 0, -1, '0, -1);
    check("zero_rk1", cap_rk1, 128'h62636363626363636263636362636363);
    check("zero_rk10", cap_rk10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    idle_check();

    // back-to-back: second key held valid through the first expansion
    k = rand128();
    check("b2b_key_ready", key_ready, 1);
    key       = k;
    key_valid = 1'b1;
    model_push(k);
    @(negedge clock);
    key = 128'h000102030405060708090a0b0c0d0e0f;
    model_push(key);
    expand_check(-1, 0, -1, '0, -1);
    @(negedge clock);
    key_valid = 1'b0;
    expand_check(-1, 0, -1, '0, -1);
    check("b2b_rk10", cap_rk10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    idle_check();

    // rk_ready dropped for 3 cycles at index 4
    accept_key(rand128());
    expand_check(4, 3, -1, '0, -1);
    idle_check();

    // key_valid pulse with another key during EXPAND must be ignored
    accept_key(rand128());
    expand_check(-1, 0, 3, rand128(), -1);
    idle_check();

    // reset mid-expansion at index 6
    accept_key(rand128());
    expand_check(-1, 0, -1, '0, 6);
    @(negedge clock);
    check("abort_hold_done", done, 0);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("post_abort_done", done, 0);
      check("post_abort_rk_valid", rk_valid, 0);
    end
    accept_key(rand128());
    expand_check(-1, 0, -1, '0, -1);
    idle_check();

    // random keys, with random rk_ready drops
    for (int n = 0; n < 4; n++) begin
      accept_key(rand128());
      expand_check(int'($urandom_range(0, 10)), int'($urandom_range(1, 3)), -1, '0, -1);
      idle_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
